// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nn_pkg
// Description : Shared fixed-point types and constants for the neural-network
//               datapath. Both the neuron and backprop blocks use it.
// Revision    : 1.0 - initial release
// ============================================================================
package nn_pkg;

    // Q8.8 signed fixed-point value.
    typedef logic signed [15:0] q8_8_t;

    localparam int    FRAC_BITS = 8;
    localparam q8_8_t Q_MAX     = 16'sh7FFF;
    localparam q8_8_t Q_MIN     = 16'sh8000;

    // Sequencer states of the multiply-accumulate engine.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        WAIT   = 2'd2,
        RESULT = 2'd3
    } mac_state_t;

endpackage : nn_pkg
`default_nettype wire

// File: rtl/fx_mul.sv
`default_nettype none
// ============================================================================
// Module      : fx_mul
// Description : Combinational signed Q8.8 x Q8.8 -> Q8.8 multiplier. The full
//               32-bit product is truncated to bits [23:8]. This is an
//               arithmetic shift right by 8, so the result rounds toward
//               minus infinity. The integer bits above bit 23 are dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module fx_mul
    import nn_pkg::*;
(
    input  q8_8_t a,
    input  q8_8_t b,
    output q8_8_t p
);

    logic signed [31:0] prod;

    // Full-precision product, then a window of the middle 16 bits.
    always_comb begin
        prod = a * b;
        p    = q8_8_t'(prod[FRAC_BITS +: 16]);
    end

    // The discarded integer and fraction bits are intentionally unused.
    logic unused_prod_bits;
    assign unused_prod_bits = &{1'b0, prod[31:FRAC_BITS+16], prod[FRAC_BITS-1:0]};

endmodule : fx_mul
`default_nettype wire

// File: rtl/neuron_mac.sv
`default_nettype none
// ============================================================================
// Module      : neuron_mac
// Description : Sequential Q8.8 multiply-accumulate for one neuron:
//               y = act(bias + sum x[k]*w[k]). It streams one term per cycle
//               from synchronous memories with one cycle of read latency. The
//               result is saturated to 16 bits and optionally passed through
//               a ReLU.
// Revision    : 1.0 - initial release
// ============================================================================
module neuron_mac
    import nn_pkg::*;
#(
    parameter int N_IN   = 8,
    parameter int ACC_W  = 24,
    parameter int ADDR_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              relu_en,
    input  logic [15:0]       bias,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [15:0]       x_data,
    input  logic [15:0]       w_data,
    output logic              busy,
    output logic              y_valid,
    output logic [15:0]       y_data,
    output logic              ovf
);

    localparam int                       EXT_W    = ACC_W - 16;
    localparam logic [ADDR_W-1:0]        LAST_IDX = ADDR_W'(N_IN - 1);
    localparam logic signed [ACC_W-1:0]  ACC_MAX  = {{EXT_W{Q_MAX[15]}}, Q_MAX};
    localparam logic signed [ACC_W-1:0]  ACC_MIN  = {{EXT_W{Q_MIN[15]}}, Q_MIN};

    mac_state_t               state;
    mac_state_t               state_nx;
    logic [ADDR_W-1:0]        cnt;
    logic [ADDR_W-1:0]        cnt_nx;
    logic                     dv;
    logic                     relu_q;
    logic signed [ACC_W-1:0]  acc;

    q8_8_t                    x_q;
    q8_8_t                    w_q;
    q8_8_t                    term;
    logic                     sat_hi;
    logic                     sat_lo;
    q8_8_t                    sat_val;
    q8_8_t                    res_val;

    assign x_q = q8_8_t'(x_data);
    assign w_q = q8_8_t'(w_data);

    fx_mul u_mul (
        .a (x_q),
        .b (w_q),
        .p (term)
    );

    // State and term-counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state logic. The counter walks 0..N_IN-1 during READ and parks at 0.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = READ;
                    cnt_nx   = '0;
                end
            end
            READ: begin
                if (cnt == LAST_IDX) begin
                    state_nx = WAIT;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + ADDR_W'(1);
                end
            end
            WAIT:    state_nx = RESULT;
            RESULT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Memory interface and busy are registered from the next-state values,
    // so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_en   <= 1'b0;
            rd_addr <= '0;
            busy    <= 1'b0;
            dv      <= 1'b0;
        end else begin
            rd_en   <= (state_nx == READ);
            rd_addr <= cnt_nx;
            busy    <= (state_nx != IDLE);
            dv      <= rd_en;
        end
    end

    // Accumulator: it is seeded with the bias on start and then adds one
    // sign-extended term per data-valid cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc    <= '0;
            relu_q <= 1'b0;
        end else if ((state == IDLE) && start) begin
            acc    <= {{EXT_W{bias[15]}}, bias};
            relu_q <= relu_en;
        end else if (dv) begin
            acc    <= acc + {{EXT_W{term[15]}}, term};
        end
    end

    // Clamp the wide accumulator to Q8.8, then apply the optional ReLU.
    always_comb begin
        sat_hi  = (acc > ACC_MAX);
        sat_lo  = (acc < ACC_MIN);
        sat_val = q8_8_t'(acc[15:0]);
        if (sat_hi) begin
            sat_val = Q_MAX;
        end else if (sat_lo) begin
            sat_val = Q_MIN;
        end
        res_val = sat_val;
        if (relu_q && sat_val[15]) begin
            res_val = '0;
        end
    end

    // Result register: it captures the value in RESULT and holds it until the
    // next RESULT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_valid <= 1'b0;
            y_data  <= '0;
            ovf     <= 1'b0;
        end else if (state == RESULT) begin
            y_valid <= 1'b1;
            y_data  <= res_val;
            ovf     <= sat_hi | sat_lo;
        end else begin
            y_valid <= 1'b0;
        end
    end

endmodule : neuron_mac
`default_nettype wire

// File: tb/tb_neuron_mac.sv
`default_nettype none
// ============================================================================
// Module      : tb_neuron_mac
// Description : Self-checking bench for neuron_mac with N_IN=4. It applies a
//               table of directed vectors and then a few hand-written
//               control sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_neuron_mac;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        relu_en = 1'b0;
    logic [15:0] bias = '0;
    logic [15:0] x_data = '0;
    logic [15:0] w_data = '0;
    logic        rd_en;
    logic [1:0]  rd_addr;
    logic        busy;
    logic        y_valid;
    logic [15:0] y_data;
    logic        ovf;

    neuron_mac #(.N_IN(N), .ACC_W(24)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .relu_en (relu_en),
        .bias    (bias),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .x_data  (x_data),
        .w_data  (w_data),
        .busy    (busy),
        .y_valid (y_valid),
        .y_data  (y_data),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    // Synchronous input/weight memories with one cycle of read latency.
    logic [15:0] xmem [N];
    logic [15:0] wmem [N];
    always @(posedge clk) begin
        if (rd_en) begin
            x_data <= xmem[rd_addr];
            w_data <= wmem[rd_addr];
        end
    end

    typedef struct {
        logic [N-1:0][15:0] x;
        logic [N-1:0][15:0] w;
        logic [15:0]        b;
        logic               relu;
        logic [15:0]        exp_y;
        logic               exp_ovf;
        string              name;
    } vec_t;

    vec_t vecs [9];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic load(input vec_t v);
        for (int i = 0; i < N; i++) begin
            xmem[i] = v.x[i];
            wmem[i] = v.w[i];
        end
    endtask

    // Runs one computation. It checks the read strobes, busy, latency, the
    // result, and that y_valid lasts a single cycle.
    task automatic run_vec(input vec_t v);
        int cyc;
        load(v);
        @(negedge clk);
        start   = 1'b1;
        bias    = v.b;
        relu_en = v.relu;
        @(negedge clk);
        start   = 1'b0;
        bias    = 16'hDEAD;      // bias/relu_en must only matter with start
        relu_en = ~v.relu;
        cyc = 1;
        while (!y_valid && cyc < 20) begin
            chk({v.name, " rd_en"}, 32'(rd_en), 32'(cyc <= N));
            if (rd_en) chk({v.name, " rd_addr"}, 32'(rd_addr), 32'(cyc - 1));
            chk({v.name, " busy"}, 32'(busy), 32'(cyc <= N + 2));
            @(negedge clk);
            cyc++;
        end
        chk({v.name, " latency"}, 32'(cyc), 32'(N + 3));
        chk({v.name, " y_data"}, 32'(y_data), 32'(v.exp_y));
        chk({v.name, " ovf"}, 32'(ovf), 32'(v.exp_ovf));
        chk({v.name, " busy at y_valid"}, 32'(busy), 32'd0);
        @(negedge clk);
        chk({v.name, " y_valid pulse"}, 32'(y_valid), 32'd0);
        chk({v.name, " y_data held"}, 32'(y_data), 32'(v.exp_y));
    endtask

    initial begin
        int cyc;
        int pulses;
        int first;

        // Basic dot product: 2.0 + 2.0 - 1.0 + 2.0 + 0.5 bias
        vecs[0] = '{x: {16'h0080, 16'hFF00, 16'h0200, 16'h0100},
                    w: {16'h0400, 16'h0100, 16'h0100, 16'h0200},
                    b: 16'h0080, relu: 1'b0, exp_y: 16'h0580, exp_ovf: 1'b0, name: "basic"};
        // Truncation: 1 lsb * 1 lsb -> 0, -1 lsb * 1 lsb -> -1 lsb
        vecs[1] = '{x: {16'h0000, 16'h0000, 16'hFFFF, 16'h0001},
                    w: {16'h0000, 16'h0000, 16'h0001, 16'h0001},
                    b: 16'h0000, relu: 1'b0, exp_y: 16'hFFFF, exp_ovf: 1'b0, name: "trunc"};
        // 127*127 keeps only bits [23:8] = 0x0100 per term; 0x7F00+4*0x0100 overflows
        vecs[2] = '{x: {4{16'h7F00}}, w: {4{16'h7F00}},
                    b: 16'h7F00, relu: 1'b0, exp_y: 16'h7FFF, exp_ovf: 1'b1, name: "sat_pos"};
        // 127*(-127) gives term 0xFF00; bias -127 minus 4.0 underflows
        vecs[3] = '{x: {4{16'h7F00}}, w: {4{16'h8100}},
                    b: 16'h8100, relu: 1'b0, exp_y: 16'h8000, exp_ovf: 1'b1, name: "sat_neg"};
        // 2.0 * -3.0 = -6.0
        vecs[4] = '{x: {16'h0000, 16'h0000, 16'h0000, 16'h0200},
                    w: {16'h0000, 16'h0000, 16'h0000, 16'hFD00},
                    b: 16'h0000, relu: 1'b0, exp_y: 16'hFA00, exp_ovf: 1'b0, name: "relu_off"};
        vecs[5] = '{x: {16'h0000, 16'h0000, 16'h0000, 16'h0200},
                    w: {16'h0000, 16'h0000, 16'h0000, 16'hFD00},
                    b: 16'h0000, relu: 1'b1, exp_y: 16'h0000, exp_ovf: 1'b0, name: "relu_on"};
        vecs[6] = '{x: {4{16'h7F00}}, w: {4{16'h7F00}},
                    b: 16'h7F00, relu: 1'b1, exp_y: 16'h7FFF, exp_ovf: 1'b1, name: "relu_sat_pos"};
        // Saturated negative result clamped to zero; ovf still reports saturation
        vecs[7] = '{x: {4{16'h7F00}}, w: {4{16'h8100}},
                    b: 16'h8100, relu: 1'b1, exp_y: 16'h0000, exp_ovf: 1'b1, name: "relu_sat_neg"};
        // 1.5*1.5 + 0.25*4.0 - 1.0 = 2.25
        vecs[8] = '{x: {16'h0000, 16'h0000, 16'h0040, 16'h0180},
                    w: {16'h0000, 16'h0000, 16'h0400, 16'h0180},
                    b: 16'hFF00, relu: 1'b0, exp_y: 16'h0240, exp_ovf: 1'b0, name: "frac"};

        // Reset values
        repeat (3) @(negedge clk);
        chk("reset rd_en", 32'(rd_en), 32'd0);
        chk("reset rd_addr", 32'(rd_addr), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset y_valid", 32'(y_valid), 32'd0);
        chk("reset y_data", 32'(y_data), 32'd0);
        chk("reset ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // A start pulse in cycle 3 while busy must be ignored
        load(vecs[0]);
        @(negedge clk);
        start = 1'b1; bias = vecs[0].b; relu_en = 1'b0;
        @(negedge clk);
        start = 1'b0;
        pulses = 0; first = 0;
        for (cyc = 1; cyc < 25; cyc++) begin
            if (y_valid) begin
                pulses++;
                if (first == 0) first = cyc;
            end
            start = (cyc == 3);
            @(negedge clk);
        end
        start = 1'b0;
        chk("busy_start pulses", 32'(pulses), 32'd1);
        chk("busy_start latency", 32'(first), 32'(N + 3));
        chk("busy_start y_data", 32'(y_data), 32'h0580);

        // start in the y_valid cycle begins a new run immediately
        load(vecs[8]);
        @(negedge clk);
        start = 1'b1; bias = vecs[8].b; relu_en = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!y_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("b2b first latency", 32'(cyc), 32'(N + 3));
        chk("b2b first y_data", 32'(y_data), 32'h0240);
        load(vecs[0]);
        start = 1'b1; bias = vecs[0].b; relu_en = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("b2b rd_en rises", 32'(rd_en), 32'd1);
        chk("b2b rd_addr", 32'(rd_addr), 32'd0);
        chk("b2b busy", 32'(busy), 32'd1);
        chk("b2b y_valid drop", 32'(y_valid), 32'd0);
        cyc = 1;
        while (!y_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("b2b second latency", 32'(cyc), 32'(N + 3));
        chk("b2b second y_data", 32'(y_data), 32'h0580);

        // Reset in cycle 4 aborts the run and clears the result
        load(vecs[2]);
        @(negedge clk);
        start = 1'b1; bias = vecs[2].b; relu_en = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);  // now in cycle 4
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset busy", 32'(busy), 32'd0);
        chk("midreset rd_en", 32'(rd_en), 32'd0);
        chk("midreset y_data", 32'(y_data), 32'd0);
        chk("midreset y_valid", 32'(y_valid), 32'd0);
        rst_n = 1'b1;
        pulses = 0;
        repeat (15) begin
            @(negedge clk);
            if (y_valid) pulses++;
        end
        chk("midreset no y_valid", 32'(pulses), 32'd0);

        // Normal operation resumes after the aborted run
        run_vec(vecs[4]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_neuron_mac
`default_nettype wire

// File: doc/neuron_mac.md
# neuron_mac

Sequential Q8.8 multiply-accumulate engine computing one neuron output, y = act(bias + Σ x[k]·w[k]) for k = 0..N_IN-1. It sits directly downstream of the architecture controller. One of that controller's phase strobes, FPH (hidden-layer forward pass) or FPO (output-layer forward pass), drives `start`. The block then streams inputs and weights from synchronous memories, one term per cycle, and returns a saturated 16-bit result with a one-cycle valid pulse.

## Interface
- N_IN, 8, number of input/weight pairs; 1 ≤ N_IN ≤ 2^(ACC_W-16)-1
- ACC_W, 24, accumulator width (Q16.8 signed)
- ADDR_W, $clog2(N_IN) (min 1), read-address width
- clk  in  1  clock; all logic on posedge
- rst_n  in  1  reset; one clock, synchronous, active-low
- start  in  1  one-cycle request pulse; sampled only in IDLE
- relu_en  in  1  apply ReLU to result; sampled with start
- bias  in  16  Q8.8 signed bias; sampled with start
- rd_en  out  1  memory read strobe
- rd_addr  out  ADDR_W  term index k
- x_data  in  16  Q8.8 input; valid exactly one cycle after rd_en
- w_data  in  16  Q8.8 weight; valid exactly one cycle after rd_en
- busy  out  1  high while a computation is in flight
- y_valid  out  1  one-cycle pulse; y_data/ovf valid
- y_data  out  16  Q8.8 result; held until next result
- ovf  out  1  saturation occurred; updated with y_valid

## Operation
- FSM states: IDLE, READ, WAIT, RESULT.
- IDLE + start=1: latch relu_en; acc ← sign-extend(bias)<<0 into ACC_W; cnt ← 0; go to READ.
- READ: rd_en=1, rd_addr=cnt; cnt increments each cycle. After cnt = N_IN-1, go to WAIT.
- WAIT: one cycle; the last term accumulates.
- RESULT: y_data ← relu(sat16(acc)), ovf ← saturated, y_valid ← 1; go to IDLE.
- Term arithmetic:
  - p = signed 16×16 → 32-bit product.
  - term = p[23:8], an arithmetic right shift by 8 that truncates toward −∞.
  - The term is sign-extended to ACC_W.
  - acc ← acc + term on every cycle where dv (registered rd_en) = 1.
- Saturation: acc > 32767 → 0x7FFF; acc < −32768 → 0x8000; ovf=1 in both cases.
- ReLU: applied after saturation. A negative result → 0x0000. ovf still reflects saturation.
- The accumulator never wraps within the legal N_IN range. No intermediate saturation.
- start while busy: ignored; no queueing.
- start coincident with y_valid (IDLE cycle): accepted.
- Reset mid-operation: the FSM returns to IDLE at the next edge and the result is discarded.

## Timing
- Reset values: rd_en=0, rd_addr=0, busy=0, y_valid=0, y_data=0x0000, ovf=0, acc=0, cnt=0, dv=0.
- With start high in cycle 0:
  - rd_en high in cycles 1..N_IN, with rd_addr=k in cycle k+1.
  - Data for k arrives in cycle k+2 and accumulates at the end of that cycle.
  - WAIT is cycle N_IN+1; RESULT is cycle N_IN+2.
  - y_valid is high in cycle N_IN+3 only.
- Latency: start → y_valid = N_IN+3 cycles.
- busy is high in cycles 1..N_IN+2 and low when y_valid is high.
- Throughput: one result per N_IN+3 cycles when start is reissued in the y_valid cycle.
- Outputs are registered. The only combinational path is memory data → multiplier → accumulator input.

## Structure
- Shared package nn_pkg:
  - typedef q8_8_t (logic signed [15:0])
  - FRAC_BITS=8, Q_MAX=16'sh7FFF, Q_MIN=16'sh8000
  - mac_state_t enum {IDLE, READ, WAIT, RESULT}
  - this package is reused by all neuron and backprop blocks
- Sub-module fx_mul: combinational signed Q8.8 × Q8.8 → Q8.8, truncating [23:8]. Also reused by the backprop stages.

## Test plan
- Basic dot product, N_IN=4:
  - x = {0x0100, 0x0200, 0xFF00, 0x0080}, w = {0x0200, 0x0100, 0x0100, 0x0400}, bias = 0x0080, relu_en=0.
  - Expect y_data = 0x0580, ovf=0, y_valid exactly in cycle 7 after start.
- Truncation:
  - x = {0x0001, 0xFFFF, 0, 0}, w = {0x0001, 0x0001, 0, 0}, bias = 0.
  - Terms are 0 and −1, so expect y_data = 0xFFFF.
- Saturation:
  - All x = w = 0x7F00, bias = 0x7F00.
  - Expect y_data = 0x7FFF, ovf=1.
  - Repeat with all w = 0x8100; expect y_data = 0x8000, ovf=1.
- ReLU:
  - x = {0x0200, 0, 0, 0}, w = {0xFD00, 0, 0, 0}, bias = 0.
  - relu_en=0 → y_data = 0xFA00; relu_en=1 → y_data = 0x0000, ovf=0.
- Control edges:
  - A start pulse in cycle 3 while busy is ignored (single y_valid).
  - start in the y_valid cycle begins a new run; rd_en rises in the next cycle.
- Reset mid-run: rst_n low in cycle 4 → next cycle busy=0, rd_en=0, y_data=0, and no y_valid follows.
